// File: rtl/guess_game_pkg.sv
// Shared types and constants for the guess-game controller: FSM encoding,
// secret-number width and the LFSR seed/step function.
package guess_game_pkg;

    localparam int LFSR_W = 3;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } state_t;

    // Maximal-length 3-bit sequence 1,2,5,3,7,6,4; never produces 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[1:0], s[2] ^ s[1]};
    endfunction

endpackage

// File: rtl/guess_game_if.sv
// Player-facing signal bundle: button requests in, game status out.
interface guess_game_if;
    import guess_game_pkg::*;

    logic              com;
    logic              inc_guess;
    logic              chk;
    logic [LFSR_W-1:0] guess;
    logic [LFSR_W-1:0] tries;
    logic              led;
    logic              win;
    logic              lose;

    modport master (output com, inc_guess, chk,
                    input  guess, tries, led, win, lose);
    modport slave  (input  com, inc_guess, chk,
                    output guess, tries, led, win, lose);

endinterface

// File: rtl/lfsr3.sv
// Secret-number generator: 3-bit LFSR that advances one step per request.
module lfsr3
    import guess_game_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       value <= LFSR_SEED;
        else if (step) value <= lfsr_next(value);
    end

endmodule

// File: rtl/guess_game_ctrl.sv
// Guess-game controller: edge-detects the three buttons and runs the
// IDLE/PLAY/WIN/LOSE round FSM, including the WIN blink divider.
module guess_game_ctrl
    import guess_game_pkg::*;
#(
    parameter int MAX_TRIES = 4,
    parameter int BLINK_DIV = 2
)(
    input  logic        clk,
    input  logic        rst,
    guess_game_if.slave bus
);

    localparam int               CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    state_t            state, state_n;
    logic [LFSR_W-1:0] guess_r, guess_n;
    logic [LFSR_W-1:0] tries_r, tries_n, tries_inc;
    logic [LFSR_W-1:0] secret, secret_n;
    logic [LFSR_W-1:0] lfsr_value;
    logic [CNT_W-1:0]  blink_cnt, blink_n;
    logic              led_r, led_n;
    logic              com_q, inc_q, chk_q;
    logic              com_ev, inc_ev, chk_ev;
    logic              lfsr_step;

    assign com_ev = bus.com       & ~com_q;
    assign inc_ev = bus.inc_guess & ~inc_q;
    assign chk_ev = bus.chk       & ~chk_q;

    lfsr3 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (lfsr_step),
        .value (lfsr_value)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            com_q     <= 1'b0;
            inc_q     <= 1'b0;
            chk_q     <= 1'b0;
            state     <= IDLE;
            guess_r   <= '0;
            tries_r   <= '0;
            secret    <= '0;
            led_r     <= 1'b0;
            blink_cnt <= '0;
        end else begin
            com_q     <= bus.com;
            inc_q     <= bus.inc_guess;
            chk_q     <= bus.chk;
            state     <= state_n;
            guess_r   <= guess_n;
            tries_r   <= tries_n;
            secret    <= secret_n;
            led_r     <= led_n;
            blink_cnt <= blink_n;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        guess_n   = guess_r;
        tries_n   = tries_r;
        secret_n  = secret;
        led_n     = led_r;
        blink_n   = blink_cnt;
        lfsr_step = 1'b0;
        tries_inc = tries_r + LFSR_W'(1);

        // A new round overrides everything; chk beats inc_guess inside PLAY.
        if (com_ev) begin
            lfsr_step = 1'b1;
            secret_n  = lfsr_value;
            state_n   = PLAY;
            guess_n   = '0;
            tries_n   = '0;
            led_n     = 1'b0;
            blink_n   = '0;
        end else begin
            case (state)
                PLAY: begin
                    if (chk_ev) begin
                        tries_n = tries_inc;
                        if (guess_r == secret) begin
                            state_n = WIN;
                            led_n   = 1'b1;
                            blink_n = '0;
                        end else if (tries_inc == LFSR_W'(MAX_TRIES)) begin
                            state_n = LOSE;
                            led_n   = 1'b1;
                        end
                    end else if (inc_ev) begin
                        guess_n = guess_r + LFSR_W'(1);
                    end
                end
                WIN: begin
                    if (blink_cnt == CNT_LAST) begin
                        led_n   = ~led_r;
                        blink_n = '0;
                    end else begin
                        blink_n = blink_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.guess = guess_r;
    assign bus.tries = tries_r;
    assign bus.led   = led_r;
    assign bus.win   = (state == WIN);
    assign bus.lose  = (state == LOSE);

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl (MAX_TRIES=4, BLINK_DIV=2) with
// hand-computed expectations checked by immediate assertions.
module tb_guess_game_ctrl;
    import guess_game_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    guess_game_if bus ();

    guess_game_ctrl #(
        .MAX_TRIES (4),
        .BLINK_DIV (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0 = com, 1 = inc_guess, 2 = chk; one-cycle press then one idle edge.
    task automatic press(input int which);
        case (which)
            0:       bus.com       = 1'b1;
            1:       bus.inc_guess = 1'b1;
            default: bus.chk       = 1'b1;
        endcase
        tick();
        bus.com       = 1'b0;
        bus.inc_guess = 1'b0;
        bus.chk       = 1'b0;
        tick();
    endtask

    task automatic check_all(input string tag, input logic [2:0] g, input logic [2:0] t,
                             input logic l, input logic w, input logic lo);
        check({tag, "_guess"}, 8'(bus.guess), 8'(g));
        check({tag, "_tries"}, 8'(bus.tries), 8'(t));
        check({tag, "_led"},   8'(bus.led),   8'(l));
        check({tag, "_win"},   8'(bus.win),   8'(w));
        check({tag, "_lose"},  8'(bus.lose),  8'(lo));
    endtask

    initial begin
        bus.com       = 1'b0;
        bus.inc_guess = 1'b0;
        bus.chk       = 1'b0;

        // Reset asserted before any clock edge, released mid-cycle.
        #1;
        check_all("rst", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        check("rst_state", 8'(dut.state), 8'(IDLE));
        #11 rst = 1'b0;

        // inc_guess and chk are ignored in IDLE.
        bus.inc_guess = 1'b1;
        tick();
        bus.inc_guess = 1'b0;
        bus.chk       = 1'b1;
        tick();
        bus.chk       = 1'b0;
        tick();
        check_all("idle", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        check("idle_state", 8'(dut.state), 8'(IDLE));

        // Round 1: secret 1, guess to 1, win on first check.
        press(0);
        check("r1_state",  8'(dut.state),  8'(PLAY));
        check("r1_secret", 8'(dut.secret), 8'd1);
        press(1);
        check("r1_guess", 8'(bus.guess), 8'd1);
        bus.chk = 1'b1;
        tick();
        bus.chk = 1'b0;
        check_all("r1_win", 3'd1, 3'd1, 1'b1, 1'b1, 1'b0);
        tick(); check("blink1", 8'(bus.led), 8'd1);
        tick(); check("blink2", 8'(bus.led), 8'd0);
        tick(); check("blink3", 8'(bus.led), 8'd0);
        tick(); check("blink4", 8'(bus.led), 8'd1);
        tick(); check("blink5", 8'(bus.led), 8'd1);
        tick(); check("blink6", 8'(bus.led), 8'd0);

        // Round 2: secret 2, guess 0 never matches, lose after 4 checks.
        press(0);
        check("r2_secret", 8'(dut.secret), 8'd2);
        check_all("r2_start", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        press(2); check_all("r2_chk1", 3'd0, 3'd1, 1'b0, 1'b0, 1'b0);
        press(2); check_all("r2_chk2", 3'd0, 3'd2, 1'b0, 1'b0, 1'b0);
        press(2); check_all("r2_chk3", 3'd0, 3'd3, 1'b0, 1'b0, 1'b0);
        press(2); check_all("r2_chk4", 3'd0, 3'd4, 1'b1, 1'b0, 1'b1);
        tick(); tick();
        check("r2_led_steady", 8'(bus.led), 8'd1);
        press(2); check_all("r2_chk5", 3'd0, 3'd4, 1'b1, 1'b0, 1'b1);
        press(1); check("r2_inc_ignored", 8'(bus.guess), 8'd0);

        // Round 3: secret 5; chk beats inc on the same edge; held inc counts once.
        press(0);
        check("r3_secret", 8'(dut.secret), 8'd5);
        bus.chk       = 1'b1;
        bus.inc_guess = 1'b1;
        tick();
        bus.chk       = 1'b0;
        bus.inc_guess = 1'b0;
        tick();
        check_all("r3_both", 3'd0, 3'd1, 1'b0, 1'b0, 1'b0);
        bus.inc_guess = 1'b1;
        repeat (10) tick();
        bus.inc_guess = 1'b0;
        tick();
        check("r3_held", 8'(bus.guess), 8'd1);

        // Eight increments from 1: passes 7 and wraps through 0 back to 1.
        for (int i = 0; i < 8; i++) begin
            press(1);
            check($sformatf("wrap%0d", i), 8'(bus.guess), 8'((2 + i) % 8));
        end
        check("wrap_tries", 8'(bus.tries), 8'd1);
        check("wrap_state", 8'(dut.state), 8'(PLAY));

        // Mid-round async reset, with com held through release.
        #2 rst = 1'b1;
        #1;
        check_all("rst2", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        check("rst2_state", 8'(dut.state), 8'(IDLE));
        bus.com = 1'b1;
        #3 rst = 1'b0;
        tick();
        bus.com = 1'b0;
        check("rst2_play",   8'(dut.state),  8'(PLAY));
        check("rst2_secret", 8'(dut.secret), 8'd1);
        tick();
        check_all("rst2_round", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
